// File: rtl/sift_pkg.sv
// ============================================================================
// Module      : sift_pkg
// Description : Shared types and constants for the SIFT keypoint collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sift_pkg;

  localparam int COORD_W = 16;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
  } key_coord_t;

  localparam logic [15:0] TRAILER_ROW = 16'hFFFF;
  localparam logic [15:0] KEY_CNT_MAX = 16'hFFFE;

endpackage

`default_nettype wire

// File: rtl/keypoint_fifo.sv
// ============================================================================
// Module      : keypoint_fifo
// Description : Synchronous first-word-fall-through FIFO with full, empty and
//               free-entry count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypoint_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_free
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_free    = (AW+1)'(DEPTH) - r_count;
  assign o_data    = r_mem[r_rd_ptr];
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/keypoint_collect.sv
// ============================================================================
// Module      : keypoint_collect
// Description : Turns marked raster pixels into (row, col) keypoint words and
//               streams them, plus a per-frame count trailer, over AXI4-Stream.
//               Optional macro KEYPOINT_BORDER_SKIP_EN drops border keypoints.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypoint_collect
  import sift_pkg::*;
#(
  parameter int KEY_COLUMN   = 510,
  parameter int KEY_ROW      = 510,
  parameter int COORD_OFFSET = 1,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic        axi_clk,
  input  logic        axi_rst,
  input  logic        key_valid,
  input  logic        key_mark,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        overflow,
  output logic        frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  key_coord_t         r_cap;
  logic               r_cap_vld;
  logic               r_fe;
  logic               r_pend_vld;
  logic [15:0]        r_pend_cnt;
  logic [15:0]        r_key_cnt;
  logic               r_ovf;

  logic               w_col_last;
  logic               w_row_last;
  logic               w_frame_end;
  logic               w_in_border;
  logic               w_cand;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [AW:0]        w_free;
  logic [AW:0]        w_free_eff;
  logic               w_trl_push;
  logic               w_key_push;
  logic               w_key_drop;
  logic [15:0]        w_key_cnt_nxt;
  logic [32:0]        w_fifo_din;
  logic [32:0]        w_fifo_q;

  assign w_col_last  = (r_col == COORD_W'(KEY_COLUMN - 1));
  assign w_row_last  = (r_row == COORD_W'(KEY_ROW - 1));
  assign w_frame_end = key_valid && w_col_last && w_row_last;

`ifdef KEYPOINT_BORDER_SKIP_EN
  assign w_in_border = (int'(r_row) >= 4) && (int'(r_row) <= KEY_ROW - 5) &&
                       (int'(r_col) >= 4) && (int'(r_col) <= KEY_COLUMN - 5);
`else
  assign w_in_border = 1'b1;
`endif

  assign w_cand = key_valid && key_mark && w_in_border;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (key_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // One slot is always kept back so a frame trailer can follow the last keypoint.
  assign w_pop         = m_axis_tvalid && m_axis_tready;
  assign w_free_eff    = w_free + (AW+1)'(w_pop);
  assign w_trl_push    = r_pend_vld && (!w_full || w_pop);
  assign w_key_push    = r_cap_vld && !r_pend_vld && (w_free_eff >= (AW+1)'(2));
  assign w_key_drop    = r_cap_vld && !w_key_push;
  assign w_key_cnt_nxt = (w_key_push && (r_key_cnt != KEY_CNT_MAX)) ? r_key_cnt + 1'b1
                                                                     : r_key_cnt;
  assign w_fifo_din    = w_trl_push ? {1'b1, TRAILER_ROW, r_pend_cnt} : {1'b0, r_cap};

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      r_cap_vld  <= 1'b0;
      r_cap      <= '0;
      r_fe       <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_cnt <= '0;
      r_key_cnt  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_cap_vld <= w_cand;
      r_cap.row <= r_row + COORD_W'(COORD_OFFSET);
      r_cap.col <= r_col + COORD_W'(COORD_OFFSET);
      r_fe      <= w_frame_end;
      if (w_key_drop || (r_fe && r_pend_vld && !w_trl_push)) r_ovf <= 1'b1;
      if (r_fe) begin
        r_key_cnt <= '0;
        // An older trailer still waiting wins; the newer frame's trailer is lost.
        if (!r_pend_vld || w_trl_push) begin
          r_pend_vld <= 1'b1;
          r_pend_cnt <= w_key_cnt_nxt;
        end
      end else begin
        r_key_cnt <= w_key_cnt_nxt;
        if (w_trl_push) r_pend_vld <= 1'b0;
      end
    end
  end

  keypoint_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (axi_clk),
    .rst     (axi_rst),
    .i_push  (w_trl_push || w_key_push),
    .i_data  (w_fifo_din),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_free  (w_free)
  );

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = m_axis_tvalid ? w_fifo_q[31:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid && w_fifo_q[32];
  assign overflow      = r_ovf;
  assign frame_done    = w_trl_push;

endmodule

`default_nettype wire
